// File: rtl/tt_um_serial_adder.sv
// Bit-serial add/subtract/accumulate on the Tiny Tapeout pin wrapper.
// One full-adder slice and a carry flop process one bit per clock, LSB first.
module tt_um_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] op_a, op_b, res, sum_reg;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nx, s;
  logic             cout, ovf, last;

  logic             start, cin, sub, acc;
  logic [WIDTH-1:0] a_in, b_in;
  logic             unused_ok;

  assign start = uio_in[0];
  assign cin   = uio_in[1];
  assign sub   = uio_in[2];
  assign acc   = uio_in[3];
  assign a_in  = ui_in[WIDTH-1:0];
  assign b_in  = ui_in[WIDTH+3:4];

  assign unused_ok = &{1'b0, ui_in, uio_in[7:4]};

  always_comb begin
    s        = op_a[0] ^ op_b[0] ^ carry;
    carry_nx = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    res_nx   = res >> 1;
    res_nx[WIDTH-1] = s;
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (last)  state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      sum_reg <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (ena) begin
      if (state != RUN) begin
        if (start) begin
          op_a  <= acc ? sum_reg : a_in;
          op_b  <= sub ? ~b_in : b_in;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
          res   <= '0;
        end
      end else begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        res   <= res_nx;
        carry <= carry_nx;
        cnt   <= cnt + CW'(1);
        // carry here is the carry into the MSB slice
        if (last) begin
          sum_reg <= res_nx;
          cout    <= carry_nx;
          ovf     <= carry ^ carry_nx;
        end
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[WIDTH-1:0] = sum_reg;
    uo_out[WIDTH] = cout;
    uo_out[5] = ovf;
    uo_out[6] = (state == RUN);
    uo_out[7] = (state == DONE);
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
